// File: rtl/speed_gate_ctrl.sv
// Control FSM for the speed-measuring entry gate: times beam A->B, reads back the divider and drives the barrier.
// Optional build macro OVERSPEED_REJECT_EN: refuse overspeeding vehicles instead of only flagging them.
module speed_gate_ctrl #(
    parameter int WIDTH_SPEED = 14,
    parameter int MIN_CYC     = 50_000,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int HOLD_CYC    = 150_000_000,
    parameter int SPEED_LIMIT = 60,
    parameter int MAX_VEH     = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sensor_a,
    input  logic                   sensor_b,
    input  logic                   sensor_exit,
    input  logic                   man_open,
    input  logic                   done,
    input  logic [WIDTH_SPEED-1:0] speed,
    input  logic [1:0]             num_veh,
    output logic                   init,
    output logic                   count,
    output logic                   cal,
    output logic                   up,
    output logic                   down,
    output logic                   en,
    output logic                   dis,
    output logic                   overspeed,
    output logic                   reject,
    output logic                   err,
    output logic                   full,
    output logic                   busy,
    output logic [WIDTH_SPEED-1:0] speed_last
);

    localparam int TW = 28;
    localparam logic [TW-1:0]          MIN_T   = TW'(MIN_CYC);
    localparam logic [TW-1:0]          TOUT_T  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]          HOLD_T  = TW'(HOLD_CYC - 1);
    localparam logic [WIDTH_SPEED-1:0] LIMIT_S = WIDTH_SPEED'(SPEED_LIMIT);
    localparam logic [1:0]             MAX_V   = 2'(MAX_VEH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        MEASURE = 3'd2,
        CALC    = 3'd3,
        DECIDE  = 3'd4,
        OPEN    = 3'd5,
        ABORT   = 3'd6
    } state_t;

    state_t state, state_nxt;
    logic [TW-1:0] tmr;

    // Bit order: {man_open, sensor_exit, sensor_b, sensor_a}
    logic [3:0] pins;
    logic [3:0] sync_p0, sync_p1, sync_p2, edge_p3;
    logic       a_edge, b_edge, exit_edge, man_edge;

    logic init_nxt, count_nxt, cal_nxt, up_nxt, down_nxt, en_nxt, dis_nxt;
    logic ovs_nxt, err_nxt, full_nxt, latch_speed;
`ifdef OVERSPEED_REJECT_EN
    logic rej_nxt;
`endif

    assign pins      = {man_open, sensor_exit, sensor_b, sensor_a};
    assign a_edge    = edge_p3[0];
    assign b_edge    = edge_p3[1];
    assign exit_edge = edge_p3[2];
    assign man_edge  = edge_p3[3];
    assign full_nxt  = (num_veh == MAX_V);
    assign busy      = (state != IDLE);

    // Stage p0..p2: two-flop synchroniser plus history; p3: registered rising edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            edge_p3 <= '0;
        end else begin
            sync_p0 <= pins;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            edge_p3 <= sync_p1 & ~sync_p2;
        end
    end

    always_comb begin
        state_nxt   = state;
        init_nxt    = 1'b0;
        count_nxt   = 1'b0;
        cal_nxt     = 1'b0;
        up_nxt      = 1'b0;
        en_nxt      = 1'b0;
        dis_nxt     = 1'b0;
        ovs_nxt     = 1'b0;
        err_nxt     = 1'b0;
        latch_speed = 1'b0;
`ifdef OVERSPEED_REJECT_EN
        rej_nxt     = 1'b0;
`endif
        down_nxt    = exit_edge && (num_veh != 2'd0);

        case (state)
            IDLE: begin
                if (a_edge && !full_nxt) begin
                    state_nxt = START;
                end else if (man_edge && !a_edge) begin
                    en_nxt    = 1'b1;
                    state_nxt = OPEN;
                end
            end
            START: begin
                init_nxt  = 1'b1;
                state_nxt = MEASURE;
            end
            MEASURE: begin
                count_nxt = 1'b1;
                if (b_edge) begin
                    if (tmr < MIN_T) begin
                        err_nxt   = 1'b1;
                        state_nxt = ABORT;
                    end else begin
                        state_nxt = CALC;
                    end
                end else if (tmr == TOUT_T) begin
                    err_nxt   = 1'b1;
                    state_nxt = ABORT;
                end
            end
            CALC: begin
                // tmr is cleared on entry, so zero marks the first CALC cycle
                cal_nxt = (tmr == '0);
                if (done) begin
                    latch_speed = 1'b1;
                    state_nxt   = DECIDE;
                end
            end
            DECIDE: begin
                ovs_nxt = (speed_last > LIMIT_S);
`ifdef OVERSPEED_REJECT_EN
                if (speed_last > LIMIT_S) begin
                    rej_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    up_nxt    = 1'b1;
                    state_nxt = OPEN;
                end
`else
                up_nxt    = 1'b1;
                state_nxt = OPEN;
`endif
            end
            OPEN: begin
                if (tmr == HOLD_T) begin
                    dis_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ABORT: begin
                init_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            tmr        <= '0;
            init       <= 1'b0;
            count      <= 1'b0;
            cal        <= 1'b0;
            up         <= 1'b0;
            down       <= 1'b0;
            en         <= 1'b0;
            dis        <= 1'b0;
            overspeed  <= 1'b0;
            err        <= 1'b0;
            full       <= 1'b0;
            speed_last <= '0;
        end else begin
            state      <= state_nxt;
            tmr        <= (state_nxt != state) ? '0 : tmr + 1'b1;
            init       <= init_nxt;
            count      <= count_nxt;
            cal        <= cal_nxt;
            up         <= up_nxt;
            down       <= down_nxt;
            en         <= en_nxt;
            dis        <= dis_nxt;
            overspeed  <= ovs_nxt;
            err        <= err_nxt;
            full       <= full_nxt;
            if (latch_speed) begin
                speed_last <= speed;
            end
        end
    end

`ifdef OVERSPEED_REJECT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reject <= 1'b0;
        end else begin
            reject <= rej_nxt;
        end
    end
`else
    assign reject = 1'b0;
`endif

endmodule

// File: tb/tb_speed_gate_ctrl.sv
// Directed self-checking bench for speed_gate_ctrl with shortened timing parameters.
module tb_speed_gate_ctrl;

    localparam int W = 14;
    localparam int I_INIT = 0, I_CAL = 1, I_UP = 2, I_DOWN = 3, I_EN = 4;
    localparam int I_DIS = 5, I_OVS = 6, I_REJ = 7, I_ERR = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         sensor_a = 1'b0, sensor_b = 1'b0, sensor_exit = 1'b0, man_open = 1'b0;
    logic         done = 1'b0;
    logic [W-1:0] speed = '0;
    logic [1:0]   num_veh = 2'd0;
    logic         init, count, cal, up, down, en, dis, overspeed, reject, err, full, busy;
    logic [W-1:0] speed_last;

    int n_chk = 0;
    int n_bad = 0;
    int cnt[9] = '{default: 0};
    int base[9] = '{default: 0};
    int cyc = 0;
    int up_cyc = 0;
    int dis_cyc = 0;

    always #5 clk = ~clk;

    speed_gate_ctrl #(
        .WIDTH_SPEED(W), .MIN_CYC(50), .TIMEOUT_CYC(1000),
        .HOLD_CYC(20), .SPEED_LIMIT(60), .MAX_VEH(3)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .sensor_a(sensor_a), .sensor_b(sensor_b), .sensor_exit(sensor_exit),
        .man_open(man_open), .done(done), .speed(speed), .num_veh(num_veh),
        .init(init), .count(count), .cal(cal), .up(up), .down(down),
        .en(en), .dis(dis), .overspeed(overspeed), .reject(reject), .err(err),
        .full(full), .busy(busy), .speed_last(speed_last)
    );

    // Pulse counters, sampled on the inactive edge
    always @(negedge clk) begin
        cyc++;
        if (init)      cnt[I_INIT]++;
        if (cal)       cnt[I_CAL]++;
        if (up)        begin cnt[I_UP]++; up_cyc = cyc; end
        if (down)      cnt[I_DOWN]++;
        if (en)        cnt[I_EN]++;
        if (dis)       begin cnt[I_DIS]++; dis_cyc = cyc; end
        if (overspeed) cnt[I_OVS]++;
        if (reject)    cnt[I_REJ]++;
        if (err)       cnt[I_ERR]++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int d(input int i);
        return cnt[i] - base[i];
    endfunction

    task automatic snap();
        @(negedge clk);
        base = cnt;
    endtask

    task automatic vehicle(input int gap, input bit give_b);
        @(negedge clk);
        sensor_a = 1'b1;
        repeat (5) @(negedge clk);
        sensor_a = 1'b0;
        if (give_b) begin
            repeat (gap - 5) @(negedge clk);
            sensor_b = 1'b1;
            repeat (5) @(negedge clk);
            sensor_b = 1'b0;
        end
    endtask

    // Stand-in for the divider: answers a few cycles after cal
    task automatic respond(input logic [W-1:0] spd);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cnt[I_CAL] != base[I_CAL]) ok = 1'b1;
        end
        chk("cal_seen", 32'(ok), 32'd1);
        if (ok) begin
            repeat (3) @(negedge clk);
            speed = spd;
            done  = 1'b1;
            @(negedge clk);
            done  = 1'b0;
            speed = '0;
        end
    endtask

    task automatic wait_idle(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        chk("idle_reached", 32'(ok), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_init", 32'(init), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_speed_last", 32'(speed_last), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: normal admission at speed 40
        snap();
        vehicle(300, 1'b1);
        respond(14'd40);
        wait_idle(3000);
        chk("t1_init", d(I_INIT), 1);
        chk("t1_cal", d(I_CAL), 1);
        chk("t1_up", d(I_UP), 1);
        chk("t1_dis", d(I_DIS), 1);
        chk("t1_err", d(I_ERR), 0);
        chk("t1_ovs", d(I_OVS), 0);
        chk("t1_speed_last", 32'(speed_last), 32'd40);
        chk("t1_hold", dis_cyc - up_cyc, 20);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: overspeed at 90
        snap();
        vehicle(300, 1'b1);
        respond(14'd90);
        wait_idle(3000);
        chk("t2_ovs", d(I_OVS), 1);
        chk("t2_speed_last", 32'(speed_last), 32'd90);
`ifdef OVERSPEED_REJECT_EN
        chk("t2_reject", d(I_REJ), 1);
        chk("t2_up", d(I_UP), 0);
        chk("t2_dis", d(I_DIS), 0);
`else
        chk("t2_reject", d(I_REJ), 0);
        chk("t2_up", d(I_UP), 1);
        chk("t2_dis", d(I_DIS), 1);
`endif

        // 3: B never arrives
        snap();
        vehicle(0, 1'b0);
        wait_idle(3000);
        chk("t3_err", d(I_ERR), 1);
        chk("t3_init", d(I_INIT), 2);
        chk("t3_cal", d(I_CAL), 0);

        // 4: B too soon after A
        snap();
        vehicle(10, 1'b1);
        wait_idle(3000);
        chk("t4_err", d(I_ERR), 1);
        chk("t4_cal", d(I_CAL), 0);
        chk("t4_up", d(I_UP), 0);

        // manual open
        snap();
        @(negedge clk);
        man_open = 1'b1;
        repeat (5) @(negedge clk);
        man_open = 1'b0;
        wait_idle(200);
        chk("man_en", d(I_EN), 1);
        chk("man_dis", d(I_DIS), 1);
        chk("man_up", d(I_UP), 0);

        // 5: full lot, exit path
        snap();
        num_veh = 2'd3;
        repeat (2) @(negedge clk);
        chk("t5_full", 32'(full), 32'd1);
        vehicle(0, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_init", d(I_INIT), 0);
        chk("t5_busy", 32'(busy), 32'd0);
        sensor_exit = 1'b1;
        repeat (5) @(negedge clk);
        sensor_exit = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_down", d(I_DOWN), 1);
        num_veh = 2'd0;
        sensor_exit = 1'b1;
        repeat (5) @(negedge clk);
        sensor_exit = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_down_empty", d(I_DOWN), 1);
        chk("t5_not_full", 32'(full), 32'd0);

        // 6: reset in MEASURE, then a normal vehicle
        vehicle(0, 1'b0);
        repeat (50) @(negedge clk);
        chk("t6_busy_pre", 32'(busy), 32'd1);
        chk("t6_count_pre", 32'(count), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_count_rst", 32'(count), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_speed_last_rst", 32'(speed_last), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        snap();
        vehicle(300, 1'b1);
        respond(14'd40);
        wait_idle(3000);
        chk("t6_up", d(I_UP), 1);
        chk("t6_speed_last", 32'(speed_last), 32'd40);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
